// File: rtl/board_state.sv
// Authoritative 15x15 gobang board: alternating-turn stone placement with
// registered game status and combinational 9-cell line windows around a query cell.
module board_state #(
  parameter int BOARD_SIZE = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       lock,
  input  logic       place_req,
  input  logic [3:0] place_i,
  input  logic [3:0] place_j,
  output logic       place_ack,
  output logic       place_ok,
  output logic       turn,
  output logic [7:0] move_count,
  output logic       board_full,
  output logic [3:0] last_i,
  output logic [3:0] last_j,
  input  logic [3:0] get_i,
  input  logic [3:0] get_j,
  output logic [8:0] black_i,
  output logic [8:0] black_j,
  output logic [8:0] black_ij,
  output logic [8:0] black_ji,
  output logic [8:0] white_i,
  output logic [8:0] white_j,
  output logic [8:0] white_ij,
  output logic [8:0] white_ji
);

  localparam int CELLS = BOARD_SIZE * BOARD_SIZE;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [7:0] FULL_COUNT = 8'(CELLS);

  logic [CELLS-1:0] black_q, black_d;
  logic [CELLS-1:0] white_q, white_d;
  logic             turn_q, turn_d;
  logic [7:0]       move_count_q, move_count_d;
  logic             board_full_q, board_full_d;
  logic [3:0]       last_i_q, last_i_d;
  logic [3:0]       last_j_q, last_j_d;
  logic             ack_q, ack_d;
  logic             ok_q, ok_d;

  logic [IDX_W-1:0] place_idx;
  logic             place_in_range;
  logic             place_occupied;
  logic             accept;

  // Off-board coordinates (negative or >= BOARD_SIZE) read as empty.
  function automatic logic cell_at(input logic [CELLS-1:0] b,
                                   input logic signed [5:0] r,
                                   input logic signed [5:0] c);
    logic [IDX_W-1:0] idx;
    cell_at = 1'b0;
    if (int'(r) >= 0 && int'(r) < BOARD_SIZE && int'(c) >= 0 && int'(c) < BOARD_SIZE) begin
      idx     = IDX_W'(r[3:0]) * IDX_W'(BOARD_SIZE) + IDX_W'(c[3:0]);
      cell_at = b[idx];
    end
  endfunction

  always_comb begin
    place_in_range = (int'(place_i) < BOARD_SIZE) && (int'(place_j) < BOARD_SIZE);
    place_idx      = IDX_W'(place_i) * IDX_W'(BOARD_SIZE) + IDX_W'(place_j);
    place_occupied = 1'b0;
    if (place_in_range) place_occupied = black_q[place_idx] | white_q[place_idx];
    accept = place_req && !lock && place_in_range && !place_occupied;
  end

  always_comb begin
    black_d      = black_q;
    white_d      = white_q;
    turn_d       = turn_q;
    move_count_d = move_count_q;
    last_i_d     = last_i_q;
    last_j_d     = last_j_q;
    ack_d        = 1'b0;
    ok_d         = 1'b0;
    if (clr) begin
      black_d      = '0;
      white_d      = '0;
      turn_d       = 1'b0;
      move_count_d = '0;
      last_i_d     = '0;
      last_j_d     = '0;
    end else if (place_req) begin
      ack_d = 1'b1;
      if (accept) begin
        if (turn_q) white_d[place_idx] = 1'b1;
        else        black_d[place_idx] = 1'b1;
        turn_d       = ~turn_q;
        move_count_d = move_count_q + 8'd1;
        last_i_d     = place_i;
        last_j_d     = place_j;
        ok_d         = 1'b1;
      end
    end
    board_full_d = (move_count_d == FULL_COUNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      black_q      <= '0;
      white_q      <= '0;
      turn_q       <= 1'b0;
      move_count_q <= '0;
      board_full_q <= 1'b0;
      last_i_q     <= '0;
      last_j_q     <= '0;
      ack_q        <= 1'b0;
      ok_q         <= 1'b0;
    end else begin
      black_q      <= black_d;
      white_q      <= white_d;
      turn_q       <= turn_d;
      move_count_q <= move_count_d;
      board_full_q <= board_full_d;
      last_i_q     <= last_i_d;
      last_j_q     <= last_j_d;
      ack_q        <= ack_d;
      ok_q         <= ok_d;
    end
  end

  assign place_ack  = ack_q;
  assign place_ok   = ok_q;
  assign turn       = turn_q;
  assign move_count = move_count_q;
  assign board_full = board_full_q;
  assign last_i     = last_i_q;
  assign last_j     = last_j_q;

  // Six-bit signed coordinates: 14+4 = 18 must not wrap back onto the board.
  logic signed [5:0] gi, gj, d;
  logic              query_ok;

  always_comb begin
    black_i  = '0;
    black_j  = '0;
    black_ij = '0;
    black_ji = '0;
    white_i  = '0;
    white_j  = '0;
    white_ij = '0;
    white_ji = '0;
    gi       = signed'({2'b00, get_i});
    gj       = signed'({2'b00, get_j});
    d        = '0;
    query_ok = (int'(get_i) < BOARD_SIZE) && (int'(get_j) < BOARD_SIZE);
    for (int k = 0; k < 9; k++) begin
      d = 6'(k - 4);
      if (query_ok) begin
        black_i[k]  = cell_at(black_q, gi, gj + d);
        black_j[k]  = cell_at(black_q, gi + d, gj);
        black_ij[k] = cell_at(black_q, gi + d, gj + d);
        black_ji[k] = cell_at(black_q, gi + d, gj - d);
        white_i[k]  = cell_at(white_q, gi, gj + d);
        white_j[k]  = cell_at(white_q, gi + d, gj);
        white_ij[k] = cell_at(white_q, gi + d, gj + d);
        white_ji[k] = cell_at(white_q, gi + d, gj - d);
      end
    end
  end

endmodule

// File: tb/tb_board_state.sv
// Bench for board_state: directed scenarios plus random moves, checked against
// a 2-D array model of the game and of the line windows.
module tb_board_state;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       lock = 1'b0;
  logic       place_req = 1'b0;
  logic [3:0] place_i = '0;
  logic [3:0] place_j = '0;
  logic       place_ack, place_ok, turn, board_full;
  logic [7:0] move_count;
  logic [3:0] last_i, last_j;
  logic [3:0] get_i = '0;
  logic [3:0] get_j = '0;
  logic [8:0] black_i, black_j, black_ij, black_ji;
  logic [8:0] white_i, white_j, white_ij, white_ji;

  board_state dut (
    .clk(clk), .rst(rst), .clr(clr), .lock(lock),
    .place_req(place_req), .place_i(place_i), .place_j(place_j),
    .place_ack(place_ack), .place_ok(place_ok), .turn(turn),
    .move_count(move_count), .board_full(board_full),
    .last_i(last_i), .last_j(last_j),
    .get_i(get_i), .get_j(get_j),
    .black_i(black_i), .black_j(black_j), .black_ij(black_ij), .black_ji(black_ji),
    .white_i(white_i), .white_j(white_j), .white_ij(white_ij), .white_ji(white_ji)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 empty, 1 black, 2 white.
  int mb [15][15];
  int m_turn, m_count, m_li, m_lj, m_ack, m_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) mb[r][c] = 0;
    m_turn = 0; m_count = 0; m_li = 0; m_lj = 0; m_ack = 0; m_ok = 0;
  endfunction

  function automatic logic [8:0] mwin(int col, int qi, int qj, int di, int dj);
    logic [8:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      int r, c;
      r = qi + (k - 4) * di;
      c = qj + (k - 4) * dj;
      if (qi < 15 && qj < 15 && r >= 0 && r < 15 && c >= 0 && c < 15)
        w[k] = (mb[r][c] == col);
    end
    return w;
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, ".ack"},   32'(place_ack),  32'(m_ack));
    chk({tag, ".ok"},    32'(place_ok),   32'(m_ok));
    chk({tag, ".turn"},  32'(turn),       32'(m_turn));
    chk({tag, ".count"}, 32'(move_count), 32'(m_count));
    chk({tag, ".full"},  32'(board_full), 32'(m_count == 225));
    chk({tag, ".li"},    32'(last_i),     32'(m_li));
    chk({tag, ".lj"},    32'(last_j),     32'(m_lj));
  endtask

  // Drive one cycle of inputs from a negedge, update the model at the posedge,
  // check registered outputs at the following negedge.
  task automatic step(input bit req, input int i, input int j, input bit lk, input bit cl);
    bit acc;
    place_req = req; place_i = 4'(i); place_j = 4'(j); lock = lk; clr = cl;
    @(posedge clk);
    if (cl) model_clear();
    else if (req) begin
      acc = !lk && i < 15 && j < 15 && mb[i][j] == 0;
      m_ack = 1; m_ok = int'(acc);
      if (acc) begin
        mb[i][j] = m_turn + 1;
        m_turn = 1 - m_turn; m_count++; m_li = i; m_lj = j;
      end
    end else begin
      m_ack = 0; m_ok = 0;
    end
    @(negedge clk);
    chk_status("step");
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic chk_win(input int qi, input int qj);
    get_i = 4'(qi); get_j = 4'(qj);
    #1;
    chk("black_i",  32'(black_i),  32'(mwin(1, qi, qj, 0, 1)));
    chk("black_j",  32'(black_j),  32'(mwin(1, qi, qj, 1, 0)));
    chk("black_ij", 32'(black_ij), 32'(mwin(1, qi, qj, 1, 1)));
    chk("black_ji", 32'(black_ji), 32'(mwin(1, qi, qj, 1, -1)));
    chk("white_i",  32'(white_i),  32'(mwin(2, qi, qj, 0, 1)));
    chk("white_j",  32'(white_j),  32'(mwin(2, qi, qj, 1, 0)));
    chk("white_ij", 32'(white_ij), 32'(mwin(2, qi, qj, 1, 1)));
    chk("white_ji", 32'(white_ji), 32'(mwin(2, qi, qj, 1, -1)));
  endtask

  initial begin
    int r;
    model_clear();
    repeat (2) @(negedge clk);
    chk_status("reset");
    chk_win(7, 7);
    rst = 1'b1;

    // First move and immediate repeat to the same cell.
    step(1'b1, 7, 7, 1'b0, 1'b0);
    chk_win(7, 7);
    chk("first_black_i", 32'(black_i), 32'h010);
    step(1'b1, 7, 7, 1'b0, 1'b0);
    chk("dup_ok", 32'(place_ok), 32'd0);
    idle();

    // Row of black stones at the top edge, white stones far away.
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 0, c, 1'b0, 1'b0);
      if (c < 4) step(1'b1, 10, c, 1'b0, 1'b0);
    end
    chk_win(0, 0);
    chk("edge_black_i", 32'(black_i), 32'h1F0);
    chk("edge_black_j", 32'(black_j), 32'h010);
    chk_win(0, 14);
    chk("nowrap_black_i", 32'(black_i), 32'h000);
    chk_win(14, 0);
    chk_win(15, 3);

    // Counter diagonal.
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 3, 5, 1'b0, 1'b0);
    step(1'b1, 10, 10, 1'b0, 1'b0);
    step(1'b1, 4, 4, 1'b0, 1'b0);
    step(1'b1, 10, 11, 1'b0, 1'b0);
    step(1'b1, 5, 3, 1'b0, 1'b0);
    chk_win(4, 4);
    chk("diag_black_ji", 32'(black_ji), 32'h038);

    // Rejections: lock, out-of-range row and column.
    step(1'b1, 1, 1, 1'b1, 1'b0);
    chk_win(1, 1);
    step(1'b1, 15, 2, 1'b0, 1'b0);
    step(1'b1, 2, 15, 1'b0, 1'b0);

    // clr together with a request: request dropped.
    step(1'b1, 6, 6, 1'b0, 1'b1);
    chk_win(6, 6);
    idle();

    // Reset asserted just after a request is sampled cancels its ack.
    place_req = 1'b1; place_i = 4'd4; place_j = 4'd4; lock = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 model_clear();
    chk_status("midreset");
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Random play with window queries.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12)
        step(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             ($urandom_range(0, 9) == 0), 1'b0);
      else if (r < 14) idle();
      else if (r < 19) chk_win(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      else if ($urandom_range(0, 3) == 0) step(1'b0, 0, 0, 1'b0, 1'b1);
    end

    // Fill the whole board.
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++)
      for (int j = 0; j < 15; j++) step(1'b1, i, j, 1'b0, 1'b0);
    chk("full_flag", 32'(board_full), 32'd1);
    chk("full_count", 32'(move_count), 32'd225);
    step(1'b1, 3, 3, 1'b0, 1'b0);
    chk("full_reject", 32'(place_ok), 32'd0);
    for (int n = 0; n < 10; n++)
      chk_win(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    step(1'b0, 0, 0, 1'b0, 1'b1);
    chk_win(7, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
